// File: rtl/map_tile_fetcher.sv
// Map tile fetcher: double-buffers one 40-tile map row, fetching the next line's row
// during horizontal blanking and presenting the tile code under each visible pixel.
module map_tile_fetcher (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [9:0]   hcount,
  input  logic [9:0]   vcount,
  output logic [4:0]   rdaddr,
  input  logic [159:0] rddata,
  output logic [3:0]   tile_code,
  output logic [3:0]   px_x,
  output logic [3:0]   px_y,
  output logic         tile_valid,
  output logic         overrun
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT1, WAIT2, CAPTURE, DONE} state_t;

  state_t       state_q, state_d;
  logic [159:0] active_q, active_d;
  logic [159:0] fetch_q, fetch_d;
  logic [4:0]   rdaddr_q, rdaddr_d;
  logic [3:0]   tile_code_q, tile_code_d;
  logic [3:0]   px_x_q, px_x_d;
  logic [3:0]   px_y_q, px_y_d;
  logic         tile_valid_q, tile_valid_d;
  logic         overrun_q, overrun_d;

  logic [9:0]   next_line;
  logic         next_visible;
  logic         pix_visible;
  logic [5:0]   tile_col;
  logic [7:0]   tile_msb;

  assign next_line    = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
  assign next_visible = next_line < 10'd480;
  assign pix_visible  = (hcount < 10'd640) && (vcount < 10'd480);
  assign tile_col     = hcount[9:4];
  assign tile_msb     = 8'd159 - {tile_col, 2'b00};

  // A new fetch at hcount 640 always wins, even over one still in flight.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    fetch_d   = fetch_q;
    rdaddr_d  = rdaddr_q;
    overrun_d = overrun_q;

    case (state_q)
      ADDR:    state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = CAPTURE;
      CAPTURE: begin
        state_d = DONE;
        fetch_d = rddata;
      end
      default: state_d = state_q;
    endcase

    if (hcount == 10'd640) begin
      if (next_visible) begin
        state_d  = ADDR;
        rdaddr_d = next_line[8:4];
      end
    end else if (hcount == 10'd799) begin
      if (state_q == DONE) begin
        active_d = fetch_q;
        state_d  = IDLE;
      end else if (state_q != IDLE) begin
        overrun_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_comb begin
    tile_valid_d = pix_visible;
    tile_code_d  = 4'd0;
    px_x_d       = 4'd0;
    px_y_d       = 4'd0;
    if (pix_visible) begin
      tile_code_d = active_q[tile_msb -: 4];
      px_x_d      = hcount[3:0];
      px_y_d      = vcount[3:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      active_q     <= '0;
      fetch_q      <= '0;
      rdaddr_q     <= '0;
      tile_code_q  <= '0;
      px_x_q       <= '0;
      px_y_q       <= '0;
      tile_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      fetch_q      <= fetch_d;
      rdaddr_q     <= rdaddr_d;
      tile_code_q  <= tile_code_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
      tile_valid_q <= tile_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rdaddr     = rdaddr_q;
  assign tile_code  = tile_code_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign tile_valid = tile_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_map_tile_fetcher.sv
// Bench for map_tile_fetcher: line-level reference model plus a 2-cycle-latency map RAM,
// directed scenarios (row fetch, wrap, blanking, overrun, async reset) and random lines.
module tb_map_tile_fetcher;

  logic         clk_50 = 1'b0;
  logic         rst_n;
  logic [9:0]   hcount;
  logic [9:0]   vcount;
  logic [4:0]   rdaddr;
  logic [159:0] rddata;
  logic [3:0]   tile_code;
  logic [3:0]   px_x;
  logic [3:0]   px_y;
  logic         tile_valid;
  logic         overrun;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   phase    = 0;
  logic checking = 1'b0;

  logic [159:0] mem [0:31];
  logic [159:0] ram_pipe;

  map_tile_fetcher dut (
    .CLOCK_50   (clk_50),
    .reset      (rst_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .rdaddr     (rdaddr),
    .rddata     (rddata),
    .tile_code  (tile_code),
    .px_x       (px_x),
    .px_y       (px_y),
    .tile_valid (tile_valid),
    .overrun    (overrun)
  );

  always #10 clk_50 = ~clk_50;

  // Map RAM read port with two cycles of latency.
  always @(posedge clk_50) begin
    ram_pipe <= mem[rdaddr];
    rddata   <= ram_pipe;
  end

  function automatic logic [3:0] tile_of(input logic [159:0] row, input int k);
    return 4'(row >> (4 * (39 - k)));
  endfunction

  function automatic logic [159:0] build_row(input int kind);
    logic [159:0] r;
    logic [3:0]   code;
    r = '0;
    for (int k = 0; k < 40; k++) begin
      case (kind)
        0:       code = 4'(15 - (k % 16));
        1:       code = 4'd10;
        3:       code = 4'(k % 16);
        default: code = 4'($urandom_range(0, 15));
      endcase
      r = (r << 4) | 160'(code);
    end
    return r;
  endfunction

  // Reference model: a fetch started at hcount 640 needs five more clocks before the
  // end-of-line swap can take it; an earlier hcount 799 aborts it and flags overrun.
  logic [3:0] m_active [0:39];
  logic       m_pend;
  int         m_pend_cyc;
  logic [4:0] m_pend_row;
  int         cyc = 0;
  logic [4:0] exp_rdaddr;
  logic [3:0] exp_code, exp_px_x, exp_px_y;
  logic       exp_valid, exp_overrun;
  logic [9:0] prev_h, prev_v;

  wire       m_visible   = (hcount < 10'd640) && (vcount < 10'd480);
  wire [9:0] m_next_line = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;

  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 40; k++) m_active[k] <= 4'd0;
      m_pend      <= 1'b0;
      m_pend_cyc  <= 0;
      m_pend_row  <= 5'd0;
      exp_rdaddr  <= 5'd0;
      exp_code    <= 4'd0;
      exp_px_x    <= 4'd0;
      exp_px_y    <= 4'd0;
      exp_valid   <= 1'b0;
      exp_overrun <= 1'b0;
      prev_h      <= 10'h3ff;
      prev_v      <= 10'h3ff;
    end else begin
      cyc       <= cyc + 1;
      prev_h    <= hcount;
      prev_v    <= vcount;
      exp_valid <= m_visible;
      exp_code  <= m_visible ? m_active[6'(hcount / 16)] : 4'd0;
      exp_px_x  <= m_visible ? 4'(hcount % 16) : 4'd0;
      exp_px_y  <= m_visible ? 4'(vcount % 16) : 4'd0;
      if (hcount == 10'd640) begin
        if (m_next_line < 10'd480) begin
          m_pend     <= 1'b1;
          m_pend_cyc <= cyc;
          m_pend_row <= 5'(m_next_line / 16);
          exp_rdaddr <= 5'(m_next_line / 16);
        end
      end else if (hcount == 10'd799 && m_pend) begin
        if (cyc - m_pend_cyc >= 5) begin
          for (int k = 0; k < 40; k++) m_active[k] <= tile_of(mem[m_pend_row], k);
        end else begin
          exp_overrun <= 1'b1;
        end
        m_pend <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (h=%0d v=%0d)", name, act, exp, prev_h, prev_v);
    end
  endtask

  task automatic applyStimulus(input int h, input int v);
    @(posedge clk_50);
    #2;
    hcount = 10'(h);
    vcount = 10'(v);
  endtask

  task automatic runLine(input int v, input int h_from, input int h_to);
    for (int h = h_from; h <= h_to; h++) applyStimulus(h, v);
  endtask

  // Every cycle: DUT against the model, plus literal pins at known points.
  always @(negedge clk_50) begin
    if (checking) begin
      checkOutput("tile_valid", 32'(tile_valid), 32'(exp_valid));
      checkOutput("tile_code", 32'(tile_code), 32'(exp_code));
      checkOutput("px_x", 32'(px_x), 32'(exp_px_x));
      checkOutput("px_y", 32'(px_y), 32'(exp_px_y));
      checkOutput("rdaddr", 32'(rdaddr), 32'(exp_rdaddr));
      checkOutput("overrun", 32'(overrun), 32'(exp_overrun));

      if (phase == 1 && prev_v == 10'd47 && prev_h >= 10'd640)
        checkOutput("pin_row3_rdaddr", 32'(rdaddr), 32'd3);
      if (phase == 1 && prev_v == 10'd48 && prev_h == 10'd37) begin
        checkOutput("pin_h37_code", 32'(tile_code), 32'd2);
        checkOutput("pin_h37_px_x", 32'(px_x), 32'd5);
        checkOutput("pin_h37_px_y", 32'(px_y), 32'd0);
      end
      if (phase == 1 && prev_v == 10'd48 && prev_h == 10'd639) begin
        checkOutput("pin_h639_code", 32'(tile_code), 32'd7);
        checkOutput("pin_h639_px_x", 32'(px_x), 32'd15);
      end
      if (phase == 2 && prev_v == 10'd0 && prev_h == 10'd0) begin
        checkOutput("pin_wrap_valid", 32'(tile_valid), 32'd1);
        checkOutput("pin_wrap_code", 32'(tile_code), 32'd15);
      end
      if (phase == 2 && prev_v == 10'd100 && prev_h == 10'd700) begin
        checkOutput("pin_hblank_valid", 32'(tile_valid), 32'd0);
        checkOutput("pin_hblank_code", 32'(tile_code), 32'd0);
      end
      if (phase == 2 && prev_v == 10'd500 && prev_h == 10'd100)
        checkOutput("pin_vblank_valid", 32'(tile_valid), 32'd0);
      if (phase == 3 && prev_v == 10'd21 && prev_h == 10'd100)
        checkOutput("pin_post_reset_code", 32'(tile_code), 32'd0);
      if (phase == 4 && prev_v == 10'd48 && prev_h == 10'd0) begin
        checkOutput("pin_overrun_set", 32'(overrun), 32'd1);
        checkOutput("pin_overrun_active_kept", 32'(tile_code), 32'd10);
      end
      if (phase == 4 && prev_v == 10'd49 && prev_h == 10'd37) begin
        checkOutput("pin_after_overrun_code", 32'(tile_code), 32'd2);
        checkOutput("pin_overrun_sticky", 32'(overrun), 32'd1);
      end
    end
  end

  int rv, rh, rsel, rsteps;

  initial begin
    rst_n  = 1'b0;
    hcount = 10'd0;
    vcount = 10'd0;
    for (int r = 0; r < 32; r++) mem[r] = build_row(9);
    mem[0] = build_row(0);
    mem[1] = build_row(1);
    mem[3] = build_row(3);

    repeat (3) @(posedge clk_50);
    #2 checking = 1'b1;
    @(negedge clk_50);
    checkOutput("reset_tile_valid", 32'(tile_valid), 32'd0);
    checkOutput("reset_rdaddr", 32'(rdaddr), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);

    // Release mid-line; line 47 fetches row 3 for line 48.
    applyStimulus(300, 47);
    rst_n = 1'b1;
    phase = 1;
    runLine(47, 301, 799);
    runLine(48, 0, 799);

    // Last visible line, vertical blanking, wrap fetch on 524, then hblank on line 100.
    phase = 2;
    runLine(479, 0, 799);
    runLine(500, 0, 799);
    runLine(524, 0, 799);
    runLine(0, 0, 799);
    runLine(100, 600, 799);

    // Random lines with hcount jumps and occasional fetch restarts.
    phase = 5;
    for (int n = 0; n < 30; n++) begin
      rsel = $urandom_range(0, 5);
      case (rsel)
        0:       rv = 479;
        1:       rv = 524;
        2:       rv = 478;
        default: rv = $urandom_range(0, 524);
      endcase
      if (!m_pend) mem[$urandom_range(4, 29)] = build_row(9);
      rh     = ($urandom_range(0, 1) == 0) ? 0 : 560;
      rsteps = 0;
      while (rh <= 799 && rsteps < 2000) begin
        applyStimulus(rh, rv);
        rsteps++;
        rsel = $urandom_range(0, 99);
        if (rsel < 3) rh = rh + $urandom_range(1, 200);
        else if (rsel < 6 && rh > 640 && rh < 650) rh = 640;
        else rh = rh + 1;
      end
    end

    // Async reset while the fetch sits in WAIT2.
    phase = 3;
    runLine(20, 0, 643);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rdaddr", 32'(rdaddr), 32'd0);
    checkOutput("async_tile_valid", 32'(tile_valid), 32'd0);
    checkOutput("async_tile_code", 32'(tile_code), 32'd0);
    checkOutput("async_px", 32'({px_x, px_y}), 32'd0);
    checkOutput("async_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk_50);
    #2 rst_n = 1'b1;
    runLine(20, 644, 799);
    runLine(21, 0, 799);
    runLine(22, 0, 799);

    // Missed deadline: hcount leaps from 641 to 799 while the fetch is in WAIT1.
    phase = 4;
    runLine(47, 0, 641);
    applyStimulus(799, 47);
    runLine(48, 0, 799);
    runLine(49, 0, 100);

    @(negedge clk_50);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/map_tile_fetcher.md
MAP_TILE_FETCHER -- requirements
Module: map_tile_fetcher

Interface
REQ-001 SHALL have ports: CLOCK_50 in 1, system clock; reset in 1, asynchronous, active-low; all state clears while low.
REQ-002 SHALL have port hcount in 10: VGA pixel column 0..799; visible region is 0..639.
REQ-003 SHALL have port vcount in 10: VGA line 0..524; visible region is 0..479.
REQ-004 SHALL have port rdaddr out 5: map RAM read-port address, i.e. tile row 0..29.
REQ-005 SHALL have port rddata in 160: map RAM read data; 40 tiles x 4 bits, tile 0 at [159:156].
REQ-006 SHALL have port tile_code out 4: tile code under the current pixel.
REQ-007 SHALL have ports px_x out 4 and px_y out 4: pixel offset inside the 16x16 tile.
REQ-008 SHALL have port tile_valid out 1: high when tile_code, px_x and px_y describe a visible pixel.
REQ-009 SHALL have port overrun out 1: sticky flag, set when a line fetch misses its deadline.

Function
REQ-010 SHALL map tile column = hcount[9:4] (0..39) and tile row = vcount[8:4] (0..29).
REQ-011 SHALL hold two 160-bit line buffers: active (read for display) and fetch (filled during blanking).
REQ-012 SHALL run a fetch FSM with states IDLE, ADDR, WAIT1, WAIT2, CAPTURE, DONE.
REQ-013 SHALL leave IDLE for ADDR on the cycle hcount==640, only when the next line is visible. Next line = vcount+1, wrapping 524->0; visible = next line < 480.
REQ-014 SHALL drive rdaddr = next_line[8:4] in ADDR, WAIT1, WAIT2 and CAPTURE, and hold it otherwise.
REQ-015 SHALL treat map RAM read latency as 2 cycles: rddata sampled in CAPTURE is written to the fetch buffer.
REQ-016 SHALL step ADDR->WAIT1->WAIT2->CAPTURE->DONE one state per cycle, unconditionally.
REQ-017 SHALL, on the cycle hcount==799: if FSM==DONE, copy fetch into active and go to IDLE.
REQ-018 SHALL, on the cycle hcount==799 with FSM neither DONE nor IDLE: keep active unchanged, set overrun, and go to IDLE.
REQ-019 SHALL perform no fetch after visible line 479 (next line 480..524); active is not updated and FSM stays IDLE.
REQ-020 SHALL fetch row 0 on line 524 so that line 0 of the next frame displays correctly.
REQ-021 SHALL register tile_code = active[159-4*col -: 4], px_x = hcount[3:0] and px_y = vcount[3:0]. Latency is exactly 1 clock from hcount/vcount.
REQ-022 SHALL register tile_valid = (hcount<640)&(vcount<480), with the same 1-clock latency.
REQ-023 SHALL drive tile_code=0, px_x=0 and px_y=0 whenever tile_valid is low.
REQ-024 SHALL, if hcount==640 arrives while FSM is not IDLE, restart at ADDR with the new address; no overrun is set.
REQ-025 SHALL apply overrun set-priority: overrun stays 1 until reset.
REQ-026 SHALL never write map RAM and SHALL NOT depend on the write port; concurrent writes may yield old or new row data.

Reset
REQ-027 SHALL, while reset is low: set FSM=IDLE; active and fetch buffers all-zero; rdaddr=0; tile_code=0; px_x=0; px_y=0; tile_valid=0; overrun=0.
REQ-028 SHALL, after reset deasserts mid-line, display zeros until the first completed fetch-and-swap. The first valid data appears on the line after the next hcount==640 with a visible next line.
REQ-029 SHALL let reset assert at any FSM state and return to IDLE immediately, with no partial buffer swap.

Verification
REQ-030 SHALL cover row fetch: RAM row 3 = tile k holding code k[3:0], vcount=47, sweep hcount 640..799 -> rdaddr=3 from ADDR through CAPTURE. On line 48, tile_code at hcount 16*k+j equals k[3:0], one clock late.
REQ-031 SHALL cover intra-tile offsets: on line 48, hcount=37 -> next cycle px_x=5, px_y=0, tile_code=tile 2; hcount=639 -> tile 39, px_x=15.
REQ-032 SHALL cover frame wrap: vcount=479 with hcount 640..799 -> FSM stays IDLE and active is unchanged. At vcount=524, rdaddr=0 is fetched; line 0 shows row 0 and tile_valid=1 at hcount 0 (+1 clk).
REQ-033 SHALL cover blanking: hcount=700, vcount=100 -> tile_valid=0 and tile_code=0 next cycle; vcount=500 -> tile_valid=0.
REQ-034 SHALL cover overrun: hcount jumps from 641 to 799 (FSM in WAIT1) -> overrun=1 and active is unchanged. A later normal line swaps correctly and overrun stays 1.
REQ-035 SHALL cover async reset: assert reset low in WAIT2 -> all outputs 0 within the same cycle without a clock edge. After release, line data is zero until the next swap.
